// File: rtl/canvas_port_arbiter.sv
// rtl/canvas_port_arbiter.sv - canvas frame-buffer port-A arbiter with clear sequencer
// Round-robin shares the BRAM write/compare port between two requesters and tags reads back to their issuer.
module canvas_port_arbiter #(
    parameter int                    ADDR_WIDTH   = 17,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    DEPTH        = 76800,
    parameter int                    READ_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = 8'h00
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear_start_in,
    output logic                  clear_busy_out,
    output logic                  clear_done_out,
    input  logic                  a_valid_in,
    input  logic                  a_we_in,
    input  logic [ADDR_WIDTH-1:0] a_addr_in,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    output logic                  a_ready_out,
    output logic                  a_rvalid_out,
    output logic [DATA_WIDTH-1:0] a_rdata_out,
    input  logic                  b_valid_in,
    input  logic                  b_we_in,
    input  logic [ADDR_WIDTH-1:0] b_addr_in,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    output logic                  b_ready_out,
    output logic                  b_rvalid_out,
    output logic [DATA_WIDTH-1:0] b_rdata_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [DATA_WIDTH-1:0] bram_din_out,
    output logic                  bram_we_out,
    input  logic [DATA_WIDTH-1:0] bram_dout_in
);

    localparam int                    TAG_LEN = 1 + READ_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(DEPTH);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_count;
    logic                    r_prio_b;
    logic                    r_clear_done;
    logic [ADDR_WIDTH-1:0]   r_bram_addr;
    logic [DATA_WIDTH-1:0]   r_bram_din;
    logic                    r_bram_we;
    logic [TAG_LEN-1:0]      r_tag_v;
    logic [TAG_LEN-1:0]      r_tag_b;
    logic [TAG_LEN-1:0]      r_tag_oor;
    logic                    r_a_rvalid;
    logic                    r_b_rvalid;
    logic [DATA_WIDTH-1:0]   r_a_rdata;
    logic [DATA_WIDTH-1:0]   r_b_rdata;

    logic                    w_grant_a;
    logic                    w_grant_b;
    logic                    w_grant;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_in_range;
    logic                    w_ret_v;
    logic                    w_ret_b;
    logic [DATA_WIDTH-1:0]   w_ret_data;

    // Clear start takes priority over any request presented in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_grant_a    = 1'b0;
        w_grant_b    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_start_in) begin
                    w_state_next = S_CLEAR;
                end else if (!rst_in) begin
                    w_grant_a = a_valid_in && (!b_valid_in || !r_prio_b);
                    w_grant_b = b_valid_in && (!a_valid_in || r_prio_b);
                end
            end
            S_CLEAR: begin
                if (r_count == LP_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_grant    = w_grant_a || w_grant_b;
    assign w_sel_we   = w_grant_b ? b_we_in   : a_we_in;
    assign w_sel_addr = w_grant_b ? b_addr_in : a_addr_in;
    assign w_sel_data = w_grant_b ? b_data_in : a_data_in;
    assign w_in_range = (w_sel_addr < LP_DEPTH);

    assign w_ret_v    = r_tag_v[TAG_LEN-1];
    assign w_ret_b    = r_tag_b[TAG_LEN-1];
    assign w_ret_data = r_tag_oor[TAG_LEN-1] ? '0 : bram_dout_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_prio_b     <= 1'b0;
            r_clear_done <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
            r_bram_we    <= 1'b0;
            r_tag_v      <= '0;
            r_tag_b      <= '0;
            r_tag_oor    <= '0;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
            r_a_rdata    <= '0;
            r_b_rdata    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_clear_done <= (r_state == S_CLEAR) && (r_count == LP_LAST);

            if (r_state == S_CLEAR) begin
                r_count     <= (r_count == LP_LAST) ? '0 : r_count + 1'b1;
                r_bram_addr <= r_count;
                r_bram_din  <= CLEAR_VALUE;
                r_bram_we   <= 1'b1;
            end else if (w_grant) begin
                r_count     <= '0;
                r_bram_addr <= w_sel_addr;
                r_bram_din  <= w_sel_data;
                r_bram_we   <= w_sel_we && w_in_range;
            end else begin
                r_count     <= '0;
                r_bram_we   <= 1'b0;
            end

            if (w_grant_a) begin
                r_prio_b <= 1'b1;
            end else if (w_grant_b) begin
                r_prio_b <= 1'b0;
            end

            // Owner tag rides alongside the BRAM read latency.
            r_tag_v   <= {r_tag_v[TAG_LEN-2:0],   w_grant && !w_sel_we};
            r_tag_b   <= {r_tag_b[TAG_LEN-2:0],   w_grant_b};
            r_tag_oor <= {r_tag_oor[TAG_LEN-2:0], !w_in_range};

            r_a_rvalid <= w_ret_v && !w_ret_b;
            r_b_rvalid <= w_ret_v && w_ret_b;
            if (w_ret_v && !w_ret_b) begin
                r_a_rdata <= w_ret_data;
            end
            if (w_ret_v && w_ret_b) begin
                r_b_rdata <= w_ret_data;
            end
        end
    end

    assign clear_busy_out = (r_state == S_CLEAR);
    assign clear_done_out = r_clear_done;
    assign a_ready_out    = w_grant_a;
    assign b_ready_out    = w_grant_b;
    assign a_rvalid_out   = r_a_rvalid;
    assign b_rvalid_out   = r_b_rvalid;
    assign a_rdata_out    = r_a_rdata;
    assign b_rdata_out    = r_b_rdata;
    assign bram_addr_out  = r_bram_addr;
    assign bram_din_out   = r_bram_din;
    assign bram_we_out    = r_bram_we;

endmodule

// File: doc/canvas_port_arbiter.md
Name: canvas_port_arbiter

Overview:
Single-clock controller for the write/compare port (port A) of the 320x240x8 canvas frame buffer. It shares the port between two requesters: A, the compare engine's read-modify-write traffic, and B, an auxiliary writer/reader such as an overlay or debug path. It also contains a canvas-clear sequencer that sweeps every address with a fixed value when clearing is requested. It sits between the requesters and the dual-port BRAM, and tags read returns so each read is routed back to its issuer.

Parameters:
ADDR_WIDTH, 17, BRAM address width
DATA_WIDTH, 8, pixel width
DEPTH, 76800, number of valid addresses (320*240)
READ_LATENCY, 2, BRAM port-A read latency in cycles
CLEAR_VALUE, 8'h00, value written to every address during a clear

Ports:
clk_in  input  1  system clock (65 MHz)
rst_in  input  1  asynchronous active-high reset
clear_start_in  input  1  one-cycle request to clear the canvas
clear_busy_out  output  1  high while the clear sweep is in progress
clear_done_out  output  1  one-cycle pulse when the clear completes
a_valid_in  input  1  requester A has a request
a_we_in  input  1  1 = write, 0 = read
a_addr_in  input  ADDR_WIDTH  requester A address
a_data_in  input  DATA_WIDTH  requester A write data
a_ready_out  output  1  request A accepted this cycle (combinational grant)
a_rvalid_out  output  1  read data for A is valid
a_rdata_out  output  DATA_WIDTH  read data for A
b_valid_in, b_we_in, b_addr_in, b_data_in, b_ready_out, b_rvalid_out, b_rdata_out: same as A, for requester B
bram_addr_out  output  ADDR_WIDTH  registered BRAM address
bram_din_out  output  DATA_WIDTH  registered BRAM write data
bram_we_out  output  1  registered BRAM write enable
bram_dout_in  input  DATA_WIDTH  BRAM read data

Behaviour:
- Reset (asynchronous, rst_in high): all outputs 0, FSM in IDLE, clear counter 0, round-robin pointer favours A, read-tag pipeline cleared. Reset during CLEAR aborts the sweep; the memory is left partially cleared and clear_done_out is not pulsed.
- FSM states are IDLE and CLEAR.
  - IDLE to CLEAR on clear_start_in=1. In that same cycle a_ready_out and b_ready_out are 0, so the clear wins any simultaneous request.
  - clear_start_in is ignored while in CLEAR.
- CLEAR sweep:
  - One write per cycle: address = counter (0..DEPTH-1), data = CLEAR_VALUE.
  - a_ready_out and b_ready_out are held at 0 for the whole sweep.
  - After issuing address DEPTH-1 the FSM returns to IDLE. clear_done_out pulses in the cycle after the last write is registered onto bram_*_out.
  - clear_busy_out equals (state == CLEAR); it is high for exactly DEPTH cycles.
- Arbitration in IDLE:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted most recently wins (round-robin), and the pointer updates on every grant.
  - ready is asserted in the same cycle as valid when granted. A requester holds its valid, addr and data until it sees ready.
  - Throughput is one access per cycle.
- BRAM interface:
  - An access accepted in cycle T appears on bram_addr_out/bram_din_out/bram_we_out in cycle T+1.
  - When no access is issued, bram_we_out=0 and the address holds its previous value.
- Reads:
  - An owner tag (A or B) plus a valid bit travels through a shift pipeline of length 1+READ_LATENCY.
  - bram_dout_in is captured into the owner's rdata register, and the owner's rvalid pulses for one cycle, at T+2+READ_LATENCY (T+4 with the defaults).
  - rdata_out holds its last value between returns.
  - Reads in flight at the moment a clear starts still return normally.
- Out-of-range addresses (addr >= DEPTH):
  - The request is accepted (ready asserted), and the pointer updates normally.
  - A write is dropped: bram_we_out stays 0.
  - A read still returns rvalid on schedule, with rdata = 0 instead of BRAM data.
- Read-after-write to the same address in consecutive grants returns the new data, because the BRAM is read-first per access and the operations are issued in grant order.

Test Plan:
- Reset, then A writes addr 5 = 8'hC3, then A reads addr 5 -> a_ready_out=1 on each request; a_rvalid_out pulses exactly 4 cycles after the read is accepted, with a_rdata_out=8'hC3; b_rvalid_out stays 0.
- A and B both valid for 6 consecutive cycles -> grants alternate A,B,A,B,A,B; B writes addr 100=8'h11 and A writes addr 101=8'h22, and later reads return those values to the correct owner.
- Pulse clear_start_in while A is valid -> a_ready_out=0 in that cycle; clear_busy_out high for 76800 cycles; one clear_done_out pulse; a read of addr 76799 afterwards returns 8'h00; A is granted on the first cycle after busy falls.
- A reads addr 7 one cycle before clear_start_in -> a_rvalid_out still pulses at T+4 with the pre-clear data.
- A writes addr 76800 = 8'hFF, then reads addr 76800 -> bram_we_out remains 0; the read returns rvalid with rdata=8'h00.
- Assert rst_in mid-clear at counter 1000 -> outputs go to 0 immediately, clear_busy_out=0, no clear_done_out pulse; after release, A is granted normally.
